// File: rtl/i2c_pkg.sv
// i2c_pkg
// Shared definitions for the I2C register target: the controller FSM state
// encoding, the ACK/NACK bit levels, the out-of-range read value and a helper
// that turns a data/ACK bit into an open-drain "pull low" request.
// Ports: none (package).
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    DEV,
    DEV_ACK,
    PTR,
    PTR_ACK,
    WDAT,
    WDAT_ACK,
    RDAT,
    RDAT_ACK,
    IGNORE
  } i2c_state_t;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  // Value returned for any register index beyond the implemented depth.
  localparam logic [7:0] OOR_READ = 8'hFF;

  // Open-drain: a 0 on the wire is a pull-down, a 1 is a release.
  function automatic logic drive_low(input logic bit_val);
    return (bit_val == 1'b0);
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync
// Brings the asynchronous SCL/SDA lines into the clk domain through two-flop
// synchronizers, and derives SCL rise/fall strobes plus START/STOP strobes
// from the synchronized lines. All strobes are single-clk pulses.
// Ports:
//   clk, rst     - system clock, asynchronous active-low reset
//   scl_in       - raw SCL line
//   sda_in       - raw SDA line
//   sda          - synchronized SDA (for bit sampling)
//   scl_rise     - synchronized SCL rising edge
//   scl_fall     - synchronized SCL falling edge
//   start_det    - SDA fell while SCL high
//   stop_det     - SDA rose while SCL high
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  // Bits [1:0] are the synchronizer pair, bit [2] is the previous
  // synchronized value used for edge detection. Reset to the idle-bus level
  // so that leaving reset never looks like an edge on a released bus.
  logic [2:0] scl_pipe;
  logic [2:0] sda_pipe;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_pipe <= 3'b111;
      sda_pipe <= 3'b111;
    end else begin
      scl_pipe <= {scl_pipe[1:0], scl_in};
      sda_pipe <= {sda_pipe[1:0], sda_in};
    end
  end

  assign sda       = sda_pipe[1];
  assign scl_rise  =  scl_pipe[1] & ~scl_pipe[2];
  assign scl_fall  = ~scl_pipe[1] &  scl_pipe[2];
  // SCL must be high both before and after the SDA transition.
  assign start_det =  scl_pipe[1] &  scl_pipe[2] & ~sda_pipe[1] &  sda_pipe[2];
  assign stop_det  =  scl_pipe[1] &  scl_pipe[2] &  sda_pipe[1] & ~sda_pipe[2];

endmodule

// File: rtl/i2c_reg_target.sv
// i2c_reg_target
// I2C target exposing a bank of 8-bit registers. A write transaction sets a
// register pointer and then writes data bytes; a read transaction (usually
// after a pointer write and repeated START) returns register contents.
// Optional feature macro: I2C_TGT_AUTOINC_EN - when defined, the pointer
// advances after every ACKed write byte and every controller-ACKed read byte.
// Parameters: DEV_ADDR (7-bit address), REG_DEPTH (1..256), RST_VAL.
// Ports:
//   clk, rst   - system clock, asynchronous active-low reset
//   scl_io     - I2C clock (input only)
//   sda_io     - I2C data, open-drain (0 or Z)
//   wr_stb     - one-clk pulse per register written
//   wr_addr    - register index of the write
//   wr_data    - data byte of the write
//   dbg_addr   - local read index
//   dbg_data   - register[dbg_addr], 8'hFF when out of range
//   busy       - addressed transaction in progress
module i2c_reg_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR  = 7'h21,
  parameter int         REG_DEPTH = 16,
  parameter logic [7:0] RST_VAL   = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_io,
  inout  wire        sda_io,
  output logic       wr_stb,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic [7:0] dbg_addr,
  output logic [7:0] dbg_data,
  output logic       busy
);

  localparam int AW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_in    (scl_io),
    .sda_in    (sda_io),
    .sda       (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  i2c_state_t state, state_n;
  logic [3:0] bit_cnt, cnt_n;
  logic [7:0] shift, shift_n;
  logic [7:0] ptr, ptr_n, ptr_inc;
  logic       rw, rw_n;
  logic       ack_q, ack_n;
  logic       sda_low, sda_low_n;
  logic       busy_n;
  logic       reg_we;
  logic       wr_stb_n;
  logic [7:0] wr_addr_n, wr_data_n;
  logic [7:0] rd_cur, rd_inc;
  logic [7:0] regs [REG_DEPTH];

  logic ptr_ok, ptr_inc_ok, dbg_ok;

  assign ptr_ok     = (32'(ptr)      < REG_DEPTH);
  assign ptr_inc_ok = (32'(ptr_inc)  < REG_DEPTH);
  assign dbg_ok     = (32'(dbg_addr) < REG_DEPTH);

`ifdef I2C_TGT_AUTOINC_EN
  assign ptr_inc = ptr + 8'd1;
`else
  assign ptr_inc = ptr;
`endif

  // rd_inc is the byte that follows an ACKed read; without auto-increment it
  // is simply the same register again.
  assign rd_cur   = ptr_ok     ? regs[ptr[AW-1:0]]      : OOR_READ;
  assign rd_inc   = ptr_inc_ok ? regs[ptr_inc[AW-1:0]]  : OOR_READ;
  assign dbg_data = dbg_ok     ? regs[dbg_addr[AW-1:0]] : OOR_READ;

  // Reset gates the pull-down combinationally so the line is released the
  // moment reset asserts, without waiting for a clock.
  assign sda_io = (sda_low && rst) ? 1'b0 : 1'bz;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shift   <= '0;
      ptr     <= '0;
      rw      <= 1'b0;
      ack_q   <= NACK;
      sda_low <= 1'b0;
      busy    <= 1'b0;
      wr_stb  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state   <= state_n;
      bit_cnt <= cnt_n;
      shift   <= shift_n;
      ptr     <= ptr_n;
      rw      <= rw_n;
      ack_q   <= ack_n;
      sda_low <= sda_low_n;
      busy    <= busy_n;
      wr_stb  <= wr_stb_n;
      wr_addr <= wr_addr_n;
      wr_data <= wr_data_n;
    end
  end

  // Register file; the written byte is the completed shift register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_DEPTH; i++) regs[i] <= RST_VAL;
    end else if (reg_we) begin
      regs[ptr[AW-1:0]] <= shift;
    end
  end

  // Next-state logic. Data bits are sampled on SCL rise; every change to the
  // SDA drive is made on SCL fall so it lands while SCL is low. STOP and
  // START override whatever the FSM is doing.
  always_comb begin
    state_n   = state;
    cnt_n     = bit_cnt;
    shift_n   = shift;
    ptr_n     = ptr;
    rw_n      = rw;
    ack_n     = ack_q;
    sda_low_n = sda_low;
    busy_n    = busy;
    reg_we    = 1'b0;
    wr_stb_n  = 1'b0;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;

    if (stop_det) begin
      state_n   = IDLE;
      sda_low_n = 1'b0;
      busy_n    = 1'b0;
    end else if (start_det) begin
      state_n   = DEV;
      cnt_n     = '0;
      sda_low_n = 1'b0;
    end else begin
      unique case (state)
        IDLE, IGNORE: begin
        end

        DEV: begin
          if (scl_rise) begin
            shift_n = {shift[6:0], sda_s};
            cnt_n   = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            cnt_n = '0;
            if (shift[7:1] == DEV_ADDR) begin
              state_n   = DEV_ACK;
              sda_low_n = drive_low(ACK);
              rw_n      = shift[0];
              busy_n    = 1'b1;
            end else begin
              state_n   = IGNORE;
              sda_low_n = 1'b0;
              busy_n    = 1'b0;
            end
          end
        end

        DEV_ACK: begin
          if (scl_fall) begin
            if (rw) begin
              state_n   = RDAT;
              shift_n   = rd_cur;
              sda_low_n = drive_low(rd_cur[7]);
            end else begin
              state_n   = PTR;
              sda_low_n = 1'b0;
            end
          end
        end

        PTR: begin
          if (scl_rise) begin
            shift_n = {shift[6:0], sda_s};
            cnt_n   = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            cnt_n     = '0;
            ptr_n     = shift;
            state_n   = PTR_ACK;
            sda_low_n = drive_low(ACK);
          end
        end

        PTR_ACK: begin
          if (scl_fall) begin
            state_n   = WDAT;
            sda_low_n = 1'b0;
          end
        end

        WDAT: begin
          if (scl_rise) begin
            shift_n = {shift[6:0], sda_s};
            cnt_n   = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            cnt_n   = '0;
            state_n = WDAT_ACK;
            if (ptr_ok) begin
              reg_we    = 1'b1;
              wr_stb_n  = 1'b1;
              wr_addr_n = ptr;
              wr_data_n = shift;
              ptr_n     = ptr_inc;
              sda_low_n = drive_low(ACK);
            end else begin
              sda_low_n = drive_low(NACK);
            end
          end
        end

        WDAT_ACK: begin
          if (scl_fall) begin
            state_n   = WDAT;
            sda_low_n = 1'b0;
          end
        end

        RDAT: begin
          if (scl_rise) begin
            cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              cnt_n     = '0;
              state_n   = RDAT_ACK;
              sda_low_n = 1'b0;
            end else begin
              // shift[6] is the bit that follows the one just clocked out.
              shift_n   = {shift[6:0], 1'b0};
              sda_low_n = drive_low(shift[6]);
            end
          end
        end

        RDAT_ACK: begin
          if (scl_rise) begin
            ack_n = sda_s;
          end else if (scl_fall) begin
            if (ack_q == ACK) begin
              state_n   = RDAT;
              ptr_n     = ptr_inc;
              shift_n   = rd_inc;
              sda_low_n = drive_low(rd_inc[7]);
            end else begin
              state_n   = IGNORE;
              sda_low_n = 1'b0;
            end
          end
        end

        default: begin
          state_n   = IDLE;
          sda_low_n = 1'b0;
        end
      endcase
    end
  end

endmodule
